nnrv_wb_arb: RTL and testbench
==============================

Name: nnrv_wb_arb

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback stream (port A) and a long-latency unit such as a divider (port B).
- Port A can never stall and always has priority when it actually writes.
- Port B results are queued in a small FIFO and drained into idle write-port cycles.
- A starvation counter raises a stall request so the pipeline inserts a bubble and the queue can drain.

Parameters:
- XLEN, 32, register data width
- LU_DEPTH, 2, port B FIFO depth in entries (power of 2, >=2)
- STARVE_MAX, 8, cycles a non-empty FIFO may go without a pop before stall request (>=1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_wb_en  in  1  port A write enable (from writeback stage)
- i_wb_rd  in  5  port A destination register
- i_wb_data  in  XLEN  port A write data
- i_lu_valid  in  1  port B result valid
- i_lu_rd  in  5  port B destination register
- i_lu_data  in  XLEN  port B result data
- o_lu_ready  out  1  port B accept; handshake completes when valid && ready
- o_lu_pending  out  1  FIFO non-empty (to hazard unit)
- o_stall_req  out  1  request pipeline bubble on port A
- o_reg_w_en  out  1  register-file write enable
- o_reg_w  out  5  register-file write index
- o_reg_w_reg  out  XLEN  register-file write data

Behaviour:
- Reset: one cycle of i_rst high clears FIFO (count=0, rd/wr ptr=0), wait_cnt=0, state=S_IDLE. While i_rst is high, force o_reg_w_en=0, o_reg_w=0, o_reg_w_reg=0, o_lu_ready=0, o_stall_req=0, o_lu_pending=0. Reset mid-queue discards entries.
- a_wr = i_wb_en && (i_wb_rd != 0). Writes to x0 on either port never reach the write port.
- Write port is combinational, zero latency from inputs/FIFO head:
  - If a_wr: drive port A.
  - Else if count>0: drive FIFO head {rd,data} and pop.
  - Else: o_reg_w_en=0, o_reg_w=0, o_reg_w_reg=0.
- o_lu_ready = (count < LU_DEPTH). Depends only on registered state, never on i_lu_valid.
- Push: i_lu_valid && o_lu_ready && i_lu_rd != 0 writes {rd,data} at wr_ptr.
  - rd==0: handshake completes, nothing stored.
- No bypass: a pushed entry reaches the write port at earliest the next cycle.
- Push and pop in the same cycle are legal: count unchanged, pointers both advance, wrap mod LU_DEPTH.
- Ordering: FIFO is strictly in-order. Port A vs B same-rd ordering (WAW) is guaranteed by the hazard unit via o_lu_pending, not by this block.
- wait_cnt, width clog2(STARVE_MAX+1):
  - pop: 0
  - count>0 and no pop: +1, saturating at STARVE_MAX
  - count==0: 0
- FSM, registered:
  - S_IDLE: count==0. Goes to S_WAIT when count becomes >0.
  - S_WAIT: goes to S_STALL when wait_cnt reaches STARVE_MAX. Goes to S_IDLE when a pop empties the FIFO.
  - S_STALL: o_stall_req=1. Leaves on the first pop: to S_WAIT if entries remain, else S_IDLE.
  - Push on the same cycle as the last pop keeps the FSM in S_WAIT.
- o_stall_req = (state==S_STALL), registered. o_lu_pending = (count != 0).
- Stall handling: the pipeline must produce a cycle with a_wr=0 after seeing o_stall_req. The arbiter grants the FIFO head that cycle; no other special action.

Decomposition:
- Shared package nnrv_pkg: XLEN, REG_IDX_W=5, FSM state encoding (S_IDLE/S_WAIT/S_STALL), wb request struct {en, rd, data}.
- One sub-module: nnrv_wb_fifo, a generic synchronous FIFO with push/pop/count/head and parameters WIDTH and DEPTH, reused later for other queues.

Test Plan:
- Port A only, rd=5, data=0xDEADBEEF, B idle -> same-cycle o_reg_w_en=1, o_reg_w=5, o_reg_w_reg=0xDEADBEEF; o_lu_pending=0.
- B push rd=3, data=0x11 while A idle -> next cycle write rd=3, data=0x11; o_lu_pending high for exactly that cycle.
- B push x0, then A writes x0 -> no write-port activity, o_lu_ready stays 1, count stays 0.
- LU_DEPTH=2, B pushes 3 back-to-back while A writes every cycle -> o_lu_ready=0 after 2 pushes; third held.
- Continuing that case -> after STARVE_MAX=8 cycles o_stall_req=1. A bubble pops head; stall drops next cycle. Third push is accepted on the freed slot.
- Assert i_rst with 2 entries queued and o_stall_req=1 -> next cycle count=0, o_stall_req=0, o_lu_pending=0, no stale writes afterward.

Source files
------------

// File: rtl/nnrv_pkg.sv
// Shared types and constants for the register-file writeback path.
package nnrv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 en;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/nnrv_wb_arb_if.sv
// Writeback-arbiter bus: pipeline port A, long-latency port B and the register-file write port.
interface nnrv_wb_arb_if #(
    parameter int XLEN = 32
);
    logic            i_wb_en;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            i_lu_valid;
    logic [4:0]      i_lu_rd;
    logic [XLEN-1:0] i_lu_data;
    logic            o_lu_ready;
    logic            o_lu_pending;
    logic            o_stall_req;
    logic            o_reg_w_en;
    logic [4:0]      o_reg_w;
    logic [XLEN-1:0] o_reg_w_reg;

    modport slave (
        input  i_wb_en, i_wb_rd, i_wb_data, i_lu_valid, i_lu_rd, i_lu_data,
        output o_lu_ready, o_lu_pending, o_stall_req, o_reg_w_en, o_reg_w, o_reg_w_reg
    );

    modport master (
        output i_wb_en, i_wb_rd, i_wb_data, i_lu_valid, i_lu_rd, i_lu_data,
        input  o_lu_ready, o_lu_pending, o_stall_req, o_reg_w_en, o_reg_w, o_reg_w_reg
    );
endinterface

// File: rtl/nnrv_wb_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module nnrv_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; data needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/nnrv_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue
// behind it and a starvation counter requests a pipeline bubble to drain them.
module nnrv_wb_arb
    import nnrv_pkg::*;
#(
    parameter int XLEN       = nnrv_pkg::XLEN,
    parameter int LU_DEPTH   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    nnrv_wb_arb_if.slave  bus
);
    localparam int CNT_W  = $clog2(LU_DEPTH+1);
    localparam int WAIT_W = $clog2(STARVE_MAX+1);
    localparam int ENT_W  = REG_IDX_W + XLEN;

    logic                 a_wr_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 lu_ready_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [ENT_W-1:0]     head_s;
    logic [CNT_W-1:0]     count_s;
    logic [CNT_W-1:0]     count_next_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [WAIT_W-1:0]    wait_next_s;
    arb_state_e           state_r;
    arb_state_e           state_next_s;
    logic                 w_en_s;
    logic [REG_IDX_W-1:0] w_idx_s;
    logic [XLEN-1:0]      w_data_s;

    assign a_wr_s     = bus.i_wb_en && (bus.i_wb_rd != 5'd0);
    assign lu_ready_s = !i_rst && !fifo_full_s;
    // x0 results complete the handshake but are dropped on the floor.
    assign push_s     = bus.i_lu_valid && lu_ready_s && (bus.i_lu_rd != 5'd0);
    assign pop_s      = !i_rst && !a_wr_s && !fifo_empty_s;

    nnrv_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (LU_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({bus.i_lu_rd, bus.i_lu_data}),
        .dout  (head_s),
        .count (count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Write-port select: port A first, then the queue head, else idle.
    always_comb begin
        w_en_s   = 1'b0;
        w_idx_s  = {REG_IDX_W{1'b0}};
        w_data_s = {XLEN{1'b0}};
        if (i_rst) begin
            w_en_s = 1'b0;
        end else if (a_wr_s) begin
            w_en_s   = 1'b1;
            w_idx_s  = bus.i_wb_rd;
            w_data_s = bus.i_wb_data;
        end else if (!fifo_empty_s) begin
            w_en_s   = 1'b1;
            w_idx_s  = head_s[ENT_W-1 -: REG_IDX_W];
            w_data_s = head_s[XLEN-1:0];
        end else begin
            w_en_s = 1'b0;
        end
    end

    // Occupancy after this cycle's push/pop and the matching starvation count.
    always_comb begin
        count_next_s = count_s;
        wait_next_s  = {WAIT_W{1'b0}};
        if (push_s && !pop_s) begin
            count_next_s = count_s + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_s - CNT_W'(1);
        end else begin
            count_next_s = count_s;
        end
        if (pop_s || fifo_empty_s) begin
            wait_next_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == WAIT_W'(STARVE_MAX)) begin
            wait_next_s = wait_cnt_r;
        end else begin
            wait_next_s = wait_cnt_r + WAIT_W'(1);
        end
    end

    // Starvation FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (count_next_s != {CNT_W{1'b0}}) state_next_s = S_WAIT;
                else                                state_next_s = S_IDLE;
            end
            S_WAIT: begin
                if (pop_s) begin
                    state_next_s = (count_next_s == {CNT_W{1'b0}}) ? S_IDLE : S_WAIT;
                end else if (wait_next_s == WAIT_W'(STARVE_MAX)) begin
                    state_next_s = S_STALL;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_STALL: begin
                if (pop_s) begin
                    state_next_s = (count_next_s == {CNT_W{1'b0}}) ? S_IDLE : S_WAIT;
                end else begin
                    state_next_s = S_STALL;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
        end
    end

    assign bus.o_reg_w_en   = w_en_s;
    assign bus.o_reg_w      = w_idx_s;
    assign bus.o_reg_w_reg  = w_data_s;
    assign bus.o_lu_ready   = lu_ready_s;
    assign bus.o_lu_pending = !i_rst && !fifo_empty_s;
    assign bus.o_stall_req  = !i_rst && (state_r == S_STALL);
endmodule

// File: tb/tb_nnrv_wb_arb.sv
// Self-checking bench for nnrv_wb_arb: directed scenarios plus a randomized run against a queue model.
module tb_nnrv_wb_arb;
    import nnrv_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_req_t q[$];
    int      starve = 0;

    nnrv_wb_arb_if #(.XLEN(32)) bus();

    nnrv_wb_arb #(.XLEN(32), .LU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic r, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(negedge clk);
        rst            = r;
        bus.i_wb_en    = we;
        bus.i_wb_rd    = wrd;
        bus.i_wb_data  = wd;
        bus.i_lu_valid = lv;
        bus.i_lu_rd    = lrd;
        bus.i_lu_data  = ld;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 5'd5, 32'hCAFE0001, 1'b1, 5'd3, 32'h22);
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL rst_w_en act=%b exp=0", bus.o_reg_w_en); end
        n_checks++; if (bus.o_reg_w !== 5'd0) begin n_fail++; $display("FAIL rst_w act=%0d exp=0", bus.o_reg_w); end
        n_checks++; if (bus.o_reg_w_reg !== 32'd0) begin n_fail++; $display("FAIL rst_w_reg act=%h exp=0", bus.o_reg_w_reg); end
        n_checks++; if (bus.o_lu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready act=%b exp=0", bus.o_lu_ready); end
        n_checks++; if (bus.o_stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_stall act=%b exp=0", bus.o_stall_req); end
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending act=%b exp=0", bus.o_lu_pending); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready act=%b exp=1", bus.o_lu_ready); end
    endtask

    task automatic test_port_a();
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w_en !== 1'b1) begin n_fail++; $display("FAIL a_w_en act=%b exp=1", bus.o_reg_w_en); end
        n_checks++; if (bus.o_reg_w !== 5'd5) begin n_fail++; $display("FAIL a_w act=%0d exp=5", bus.o_reg_w); end
        n_checks++; if (bus.o_reg_w_reg !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_w_reg act=%h exp=deadbeef", bus.o_reg_w_reg); end
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL a_pending act=%b exp=0", bus.o_lu_pending); end
    endtask

    task automatic test_lu_single();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL lu_no_bypass act=%b exp=0", bus.o_reg_w_en); end
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready act=%b exp=1", bus.o_lu_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w_en !== 1'b1) begin n_fail++; $display("FAIL lu_w_en act=%b exp=1", bus.o_reg_w_en); end
        n_checks++; if (bus.o_reg_w !== 5'd3) begin n_fail++; $display("FAIL lu_w act=%0d exp=3", bus.o_reg_w); end
        n_checks++; if (bus.o_reg_w_reg !== 32'h11) begin n_fail++; $display("FAIL lu_w_reg act=%h exp=11", bus.o_reg_w_reg); end
        n_checks++; if (bus.o_lu_pending !== 1'b1) begin n_fail++; $display("FAIL lu_pending act=%b exp=1", bus.o_lu_pending); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL lu_pending_drop act=%b exp=0", bus.o_lu_pending); end
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL lu_idle_w_en act=%b exp=0", bus.o_reg_w_en); end
    endtask

    task automatic test_x0();
        drive(1'b0, 1'b1, 5'd0, 32'h55AA55AA, 1'b1, 5'd0, 32'h77);
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL x0_w_en act=%b exp=0", bus.o_reg_w_en); end
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready act=%b exp=1", bus.o_lu_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL x0_next_w_en act=%b exp=0", bus.o_reg_w_en); end
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL x0_pending act=%b exp=0", bus.o_lu_pending); end
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_next_ready act=%b exp=1", bus.o_lu_ready); end
    endtask

    task automatic test_starve();
        drive(1'b0, 1'b1, 5'd7, 32'hA0, 1'b1, 5'd9, 32'h901);
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready0 act=%b exp=1", bus.o_lu_ready); end
        drive(1'b0, 1'b1, 5'd7, 32'hA1, 1'b1, 5'd10, 32'hA02);
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready1 act=%b exp=1", bus.o_lu_ready); end
        n_checks++; if (bus.o_reg_w !== 5'd7) begin n_fail++; $display("FAIL st_a_prio act=%0d exp=7", bus.o_reg_w); end
        for (int k = 2; k <= 8; k++) begin
            drive(1'b0, 1'b1, 5'd7, 32'hA2, 1'b1, 5'd11, 32'hB03);
            n_checks++; if (bus.o_lu_ready !== 1'b0) begin n_fail++; $display("FAIL st_full c%0d act=%b exp=0", k, bus.o_lu_ready); end
            n_checks++; if (bus.o_stall_req !== 1'b0) begin n_fail++; $display("FAIL st_early c%0d act=%b exp=0", k, bus.o_stall_req); end
        end
        drive(1'b0, 1'b1, 5'd7, 32'hA3, 1'b1, 5'd11, 32'hB03);
        n_checks++; if (bus.o_stall_req !== 1'b1) begin n_fail++; $display("FAIL st_raise act=%b exp=1", bus.o_stall_req); end
        drive(1'b0, 1'b0, 5'd7, 32'hA4, 1'b1, 5'd11, 32'hB03);
        n_checks++; if (bus.o_reg_w !== 5'd9 || bus.o_reg_w_reg !== 32'h901 || bus.o_reg_w_en !== 1'b1)
            begin n_fail++; $display("FAIL st_bubble act=%0d/%h exp=9/901", bus.o_reg_w, bus.o_reg_w_reg); end
        n_checks++; if (bus.o_stall_req !== 1'b1) begin n_fail++; $display("FAIL st_hold act=%b exp=1", bus.o_stall_req); end
        drive(1'b0, 1'b1, 5'd7, 32'hA5, 1'b1, 5'd11, 32'hB03);
        n_checks++; if (bus.o_stall_req !== 1'b0) begin n_fail++; $display("FAIL st_drop act=%b exp=0", bus.o_stall_req); end
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL st_freed act=%b exp=1", bus.o_lu_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w !== 5'd10 || bus.o_reg_w_reg !== 32'hA02)
            begin n_fail++; $display("FAIL st_drain1 act=%0d/%h exp=10/a02", bus.o_reg_w, bus.o_reg_w_reg); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w !== 5'd11 || bus.o_reg_w_reg !== 32'hB03)
            begin n_fail++; $display("FAIL st_drain2 act=%0d/%h exp=11/b03", bus.o_reg_w, bus.o_reg_w_reg); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL st_empty act=%b exp=0", bus.o_lu_pending); end
    endtask

    task automatic test_reset_midqueue();
        bit seen = 1'b0;
        drive(1'b0, 1'b1, 5'd4, 32'h1, 1'b1, 5'd12, 32'hC0);
        drive(1'b0, 1'b1, 5'd4, 32'h2, 1'b1, 5'd13, 32'hD0);
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(1'b0, 1'b1, 5'd4, 32'h3, 1'b0, 5'd0, 32'd0);
            seen = bus.o_stall_req;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mq_stall_timeout act=0 exp=1"); end
        drive(1'b1, 1'b1, 5'd4, 32'h4, 1'b1, 5'd14, 32'hE0);
        n_checks++; if (bus.o_reg_w_en !== 1'b0 || bus.o_stall_req !== 1'b0 || bus.o_lu_pending !== 1'b0)
            begin n_fail++; $display("FAIL mq_in_rst act=%b%b%b exp=000", bus.o_reg_w_en, bus.o_stall_req, bus.o_lu_pending); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_lu_pending !== 1'b0) begin n_fail++; $display("FAIL mq_pending act=%b exp=0", bus.o_lu_pending); end
        n_checks++; if (bus.o_stall_req !== 1'b0) begin n_fail++; $display("FAIL mq_stall act=%b exp=0", bus.o_stall_req); end
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL mq_stale act=%b exp=0", bus.o_reg_w_en); end
        n_checks++; if (bus.o_lu_ready !== 1'b1) begin n_fail++; $display("FAIL mq_ready act=%b exp=1", bus.o_lu_ready); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (bus.o_reg_w_en !== 1'b0) begin n_fail++; $display("FAIL mq_stale2 act=%b exp=0", bus.o_reg_w_en); end
    endtask

    task automatic test_random();
        q.delete();
        starve = 0;
        for (int c = 0; c < 400; c++) begin
            logic        r, we, lv, a_wr, pop, e_en, e_rdy;
            logic [4:0]  wrd, lrd, e_w;
            logic [31:0] wd, ld, e_d;
            int          sz;
            r   = ($urandom_range(0, 79) == 0);
            we  = ($urandom_range(0, 9) < ((c < 200) ? 9 : 5));
            if (starve == SMAX && $urandom_range(0, 1) == 1) we = 1'b0;
            wrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wd  = $urandom;
            ld  = $urandom;
            lv  = ($urandom_range(0, 1) == 1);
            drive(r, we, wrd, wd, lv, lrd, ld);
            sz   = q.size();
            a_wr = we && (wrd != 5'd0);
            e_en = 1'b0; e_w = 5'd0; e_d = 32'd0;
            if (!r && a_wr) begin e_en = 1'b1; e_w = wrd; e_d = wd; end
            else if (!r && sz > 0) begin e_en = 1'b1; e_w = q[0].rd; e_d = q[0].data; end
            e_rdy = !r && (sz < DEPTH);
            n_checks++; if (bus.o_reg_w_en !== e_en || bus.o_reg_w !== e_w || bus.o_reg_w_reg !== e_d)
                begin n_fail++; $display("FAIL rnd_write c%0d act=%b/%0d/%h exp=%b/%0d/%h", c, bus.o_reg_w_en, bus.o_reg_w, bus.o_reg_w_reg, e_en, e_w, e_d); end
            n_checks++; if (bus.o_lu_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d act=%b exp=%b", c, bus.o_lu_ready, e_rdy); end
            n_checks++; if (bus.o_lu_pending !== (!r && sz != 0)) begin n_fail++; $display("FAIL rnd_pending c%0d act=%b exp=%b", c, bus.o_lu_pending, !r && sz != 0); end
            n_checks++; if (bus.o_stall_req !== (!r && starve == SMAX)) begin n_fail++; $display("FAIL rnd_stall c%0d act=%b exp=%b", c, bus.o_stall_req, !r && starve == SMAX); end
            if (r) begin
                q.delete();
                starve = 0;
            end else begin
                pop = !a_wr && (sz > 0);
                if (pop) void'(q.pop_front());
                if (lv && e_rdy && lrd != 5'd0) q.push_back('{en: 1'b1, rd: lrd, data: ld});
                if (pop)          starve = 0;
                else if (sz > 0)  starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
                else              starve = 0;
            end
        end
    endtask

    initial begin
        bus.i_wb_en = 1'b0; bus.i_wb_rd = 5'd0; bus.i_wb_data = 32'd0;
        bus.i_lu_valid = 1'b0; bus.i_lu_rd = 5'd0; bus.i_lu_data = 32'd0;
        test_reset();
        test_port_a();
        test_lu_single();
        test_x0();
        test_starve();
        test_reset_midqueue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
